ifetch_seq: RTL and testbench

//  Instruction-fetch sequencer. Owns the PC and issues in-order fetch requests
//  to instruction memory. Tags each returned word with its PC and hands it to

---
 rtl/ifetch_seq.sv | 87 ++++++++
 tb/tb_ifetch_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/ifetch_seq.sv
// ifetch_seq: in-order instruction-fetch sequencer with PC tagging, redirect flush and a 2-entry decode buffer
//   clk, rst                  clock, synchronous active-high reset
//   halt                      gates new fetch requests
//   redirect_valid/_addr      PC redirect (ignored in BOOT), low two address bits forced to 0
//   imem_req_valid/_addr/_ready   fetch request handshake, address is the current PC
//   imem_rsp_valid/_data      in-order response words, no backpressure
//   inst_valid/_data/_pc/_ready   buffered instruction to decode
module ifetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d, drop_q, drop_d, cnt_q, cnt_d, wpos;
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic [31:0] ipc_q [2];
   logic [31:0] ipc_d [2];
   logic        redir, hs, push, pop;
   logic [31:0] rsp_pc;
   logic        unused;
   assign unused = ^redirect_addr[1:0];
   assign redir = redirect_valid && state_q != BOOT;
   assign imem_req_valid = state_q == RUN && !redirect_valid && ({1'b0, out_q} + {1'b0, cnt_q} < 3'(DEPTH));
   assign imem_req_addr = pc_q;
   assign hs = imem_req_valid && imem_req_ready;
   assign inst_valid = cnt_q != 2'd0;
   assign inst_data = data_q[0];
   assign inst_pc = ipc_q[0];
   assign pop = inst_valid && inst_ready;
   assign push = imem_rsp_valid && drop_q == 2'd0 && !redir;
   // Once all stale words are dropped, every outstanding request was issued
   // consecutively up to pc_q, so the oldest one sits 4*outstanding behind it.
   assign rsp_pc = pc_q - {28'b0, out_q, 2'b00};
   assign wpos = cnt_q - {1'b0, pop};
   always_comb begin
      state_d = state_q == BOOT ? RUN : (halt ? HALT : RUN);
      pc_d = redir ? {redirect_addr[31:2], 2'b00} : (hs ? pc_q + 32'd4 : pc_q);
      out_d = out_q + {1'b0, hs} - {1'b0, imem_rsp_valid};
      drop_d = redir ? out_q - {1'b0, imem_rsp_valid}
             : (imem_rsp_valid && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
      cnt_d = redir ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
      data_d[0] = pop ? data_q[1] : data_q[0];
      data_d[1] = data_q[1];
      ipc_d[0] = pop ? ipc_q[1] : ipc_q[0];
      ipc_d[1] = ipc_q[1];
      if (push) begin
         data_d[wpos[0]] = imem_rsp_data;
         ipc_d[wpos[0]] = rsp_pc;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q <= RESET_PC;
         out_q <= 2'd0;
         drop_q <= 2'd0;
         cnt_q <= 2'd0;
         data_q <= '{default: '0};
         ipc_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         out_q <= out_d;
         drop_q <= drop_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         ipc_q <= ipc_d;
      end
   end
endmodule

// File: tb/tb_ifetch_seq.sv
// tb_ifetch_seq: randomized bench for ifetch_seq against a queue-based fetch/memory model
module tb_ifetch_seq;
   localparam logic [31:0] RPC = 32'hFFFF_FFF8;
   logic        clk = 0, rst = 1, halt = 0, redirect_valid = 0, imem_req_ready = 0;
   logic        imem_rsp_valid = 0, inst_ready = 0;
   logic [31:0] redirect_addr = 0, imem_rsp_data = 0;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pc;
   ifetch_seq #(.RESET_PC(RPC), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] pc; int t; bit drop;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
   req_t        oq[$];
   ent_t        bq[$];
   logic [31:0] m_pc = RPC;
   bit          m_boot = 1, m_halted = 0;
   int          cyc = 0, n_chk = 0, n_err = 0;
   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask
   task automatic cycle(input bit r, input int ph, input int pr, input int prdy, input int pirdy, input int maxlat);
      bit   exp_rv, redir, hs;
      req_t e;
      ent_t b;
      @(negedge clk);
      rst = r;
      halt = int'($urandom_range(99)) < ph;
      redirect_valid = !r && int'($urandom_range(99)) < pr;
      redirect_addr = $urandom;
      imem_req_ready = int'($urandom_range(99)) < prdy;
      inst_ready = int'($urandom_range(99)) < pirdy;
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
      if (!r && oq.size() > 0) begin
         if (oq[0].t <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = word(oq[0].pc);
         end
      end
      #1;
      exp_rv = !m_boot && !m_halted && !redirect_valid && (oq.size() + bq.size() < 2);
      if (!r) begin
         chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
         if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, bq.size() > 0});
         if (bq.size() > 0) begin
            chk("inst_pc", inst_pc, bq[0].pc);
            chk("inst_data", inst_data, bq[0].d);
         end
         if (m_boot) begin
            chk("rst_inst_data", inst_data, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
         end
      end
      @(posedge clk);
      if (r) begin
         oq.delete();
         bq.delete();
         m_pc = RPC;
         m_boot = 1;
         m_halted = 0;
      end else begin
         redir = redirect_valid && !m_boot;
         hs = exp_rv && imem_req_ready;
         if (bq.size() > 0 && inst_ready) void'(bq.pop_front());
         if (imem_rsp_valid) begin
            e = oq.pop_front();
            if (!e.drop && !redir) begin
               b.pc = e.pc;
               b.d = word(e.pc);
               bq.push_back(b);
            end
         end
         if (redir) begin
            bq.delete();
            foreach (oq[i]) oq[i].drop = 1;
            m_pc = {redirect_addr[31:2], 2'b00};
         end
         if (hs) begin
            e.pc = m_pc;
            e.t = cyc + int'($urandom_range(maxlat, 1));
            e.drop = 0;
            oq.push_back(e);
            m_pc = m_pc + 32'd4;
         end
         m_halted = m_boot ? 1'b0 : halt;
         m_boot = 0;
      end
      cyc++;
   endtask
   initial begin
      repeat (2) cycle(1, 0, 0, 100, 100, 1);
      repeat (12) cycle(0, 0, 0, 100, 100, 1);
      repeat (10) cycle(0, 0, 0, 100, 0, 1);
      repeat (10) cycle(0, 0, 0, 100, 100, 1);
      repeat (10) cycle(0, 100, 0, 100, 100, 2);
      repeat (8) cycle(0, 0, 0, 100, 100, 1);
      repeat (400) cycle(0, 10, 15, 70, 60, 3);
      cycle(1, 0, 0, 100, 100, 1);
      repeat (600) cycle(0, 5, 5, 80, 70, 4);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
